// File: rtl/tri_draw_scheduler.sv
// tri_draw_scheduler: round-robin two-requester triangle queue feeding the raster engine draw/busy handshake,
// holding each draw until the engine is idle and its EX pipeline has drained.
module tri_draw_scheduler #(
    parameter int TRI_W        = 270,
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_a_valid,
    input  logic [TRI_W-1:0]           i_a_tri,
    output logic                       o_a_ready,
    input  logic                       i_b_valid,
    input  logic [TRI_W-1:0]           i_b_tri,
    output logic                       o_b_ready,
    input  logic                       i_flush,
    output logic                       o_draw,
    output logic [TRI_W-1:0]           o_tri,
    input  logic                       i_busy,
    output logic                       o_tri_done,
    output logic [15:0]                o_tri_count,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_idle
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(DRAIN_CYCLES + 1);
    localparam int TOW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, DRAIN} state_t;

    state_t             state_q;
    logic [TRI_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [LW-1:0]      level_q;
    logic               rr_q;
    logic [CW-1:0]      drain_q;
    logic [TOW-1:0]     to_q;
    logic               draw_q, done_q;
    logic [TRI_W-1:0]   tri_q;
    logic [15:0]        tri_count_q;
    logic               full, can_push, grant_a, grant_b, push, pop, done_now;

    // rr_q=0 favours A; a lone valid requester wins regardless
    assign full      = level_q == LW'(DEPTH);
    assign can_push  = !full && !i_flush;
    assign grant_a   = can_push && i_a_valid && (!i_b_valid || !rr_q);
    assign grant_b   = can_push && i_b_valid && !grant_a;
    assign push      = grant_a || grant_b;
    assign pop       = state_q == IDLE && level_q != '0 && !i_flush;
    assign done_now  = state_q == DRAIN && drain_q == '0;

    assign o_a_ready   = grant_a;
    assign o_b_ready   = grant_b;
    assign o_draw      = draw_q;
    assign o_tri       = tri_q;
    assign o_tri_done  = done_q;
    assign o_tri_count = tri_count_q;
    assign o_level     = level_q;
    assign o_idle      = level_q == '0 && state_q == IDLE && !i_a_valid && !i_b_valid;

    always_ff @(posedge i_clk)
        if (push) mem_q[wr_q] <= grant_a ? i_a_tri : i_b_tri;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            rr_q        <= 1'b0;
            drain_q     <= '0;
            to_q        <= '0;
            draw_q      <= 1'b0;
            done_q      <= 1'b0;
            tri_q       <= '0;
            tri_count_q <= '0;
        end else begin
            draw_q      <= 1'b0;
            done_q      <= done_now;
            tri_count_q <= tri_count_q + 16'(done_now);
            if (push) begin
                wr_q <= wr_q + 1'b1;
                rr_q <= grant_a;
            end
            if (i_flush) begin
                rd_q    <= wr_q;
                level_q <= '0;
            end else begin
                if (pop) rd_q <= rd_q + 1'b1;
                level_q <= level_q + LW'(push) - LW'(pop);
            end
            case (state_q)
                IDLE: if (pop) begin
                    tri_q   <= mem_q[rd_q];
                    draw_q  <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    to_q    <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY:
                    if (i_busy) state_q <= WAIT_IDLE;
                    else if (to_q == TOW'(BUSY_TIMEOUT - 1)) begin
                        draw_q  <= 1'b1;
                        state_q <= ISSUE;
                    end else to_q <= to_q + 1'b1;
                WAIT_IDLE: if (!i_busy) begin
                    drain_q <= CW'(DRAIN_CYCLES - 1);
                    state_q <= DRAIN;
                end
                DRAIN:
                    if (drain_q == '0) state_q <= IDLE;
                    else drain_q <= drain_q - 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tri_draw_scheduler.sv
// tb_tri_draw_scheduler: directed checks of arbitration, FIFO, draw handshake, drain timing, flush and reset.
module tb_tri_draw_scheduler;
    localparam int TW = 270;
    localparam int LW = 3;

    logic          clk = 1'b0, reset = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0, flush = 1'b0, busy = 1'b0;
    logic [TW-1:0] a_tri = '0, b_tri = '0;
    logic          a_ready, b_ready, draw, tri_done, idle;
    logic [TW-1:0] tri_o;
    logic [15:0]   count;
    logic [LW-1:0] level;
    int            checks = 0, failures = 0;
    int            a_idx = 0, b_idx = 0, a_base = 0, b_base = 0;
    logic          acc_a = 1'b0, acc_b = 1'b0;

    always #5 clk = ~clk;

    tri_draw_scheduler dut (
        .i_clk(clk), .i_reset(reset),
        .i_a_valid(a_valid), .i_a_tri(a_tri), .o_a_ready(a_ready),
        .i_b_valid(b_valid), .i_b_tri(b_tri), .o_b_ready(b_ready),
        .i_flush(flush), .o_draw(draw), .o_tri(tri_o), .i_busy(busy),
        .o_tri_done(tri_done), .o_tri_count(count), .o_level(level), .o_idle(idle)
    );

    function automatic logic [TW-1:0] mk(input int n);
        logic [9:0] b;
        b = 10'(n * 37 + 5);
        return {27{b}};
    endfunction

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // requesters present a new descriptor after each accepted one
    task automatic settle();
        #1;
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (acc_a) begin a_idx++; a_tri = mk(a_base + a_idx); end
        if (acc_b) begin b_idx++; b_tri = mk(b_base + b_idx); end
        settle();
    endtask

    task automatic start_a(input int base);
        a_base = base; a_idx = 0; a_tri = mk(base); a_valid = 1'b1;
        settle();
    endtask

    task automatic do_reset();
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0; busy = 1'b0;
        settle();
        cycle();
        cycle();
        reset = 1'b0;
        settle();
    endtask

    task automatic wait_draw(input int max, output int n);
        n = 0;
        while (!draw && n < max) begin cycle(); n++; end
    endtask

    task automatic wait_done(input int max, output int n, output int nd);
        n = 0; nd = 0;
        do begin
            cycle();
            n++;
            if (draw) nd++;
        end while (!tri_done && n < max);
    endtask

    initial begin
        int n, nd, nd2, nr, issued, both, hold, cyc_n, ndone;
        // reset state
        do_reset();
        chki("rst_draw", int'(draw), 0);
        chk("rst_tri", tri_o, '0);
        chki("rst_done", int'(tri_done), 0);
        chki("rst_count", int'(count), 0);
        chki("rst_level", int'(level), 0);
        chki("rst_idle", int'(idle), 1);

        // single A push, draw in T+2, done 8 cycles after the FSM sees busy low
        start_a(0);
        chki("t1_a_ready", int'(a_ready), 1);
        chki("t1_not_idle", int'(idle), 0);
        cycle();
        a_valid = 1'b0; settle();
        chki("t1_level", int'(level), 1);
        chki("t1_draw_t1", int'(draw), 0);
        cycle();
        chki("t1_draw_t2", int'(draw), 1);
        chk("t1_tri", tri_o, mk(0));
        chki("t1_level_pop", int'(level), 0);
        cycle();
        chki("t1_draw_pulse", int'(draw), 0);
        cycle();
        busy = 1'b1; settle();
        nd = 0;
        for (int i = 0; i < 10; i++) begin cycle(); if (draw) nd++; end
        chki("t1_no_repulse", nd, 0);
        busy = 1'b0; settle();
        wait_done(30, n, nd);
        chki("t1_done_lat", n, 9);
        chki("t1_count", int'(count), 1);
        cycle();
        chki("t1_done_pulse", int'(tri_done), 0);
        chki("t1_count_hold", int'(count), 1);

        // round-robin with both requesters always valid
        do_reset();
        start_a(100);
        b_base = 200; b_idx = 0; b_tri = mk(200); b_valid = 1'b1;
        settle();
        chki("t2_first_a", int'(a_ready), 1);
        chki("t2_first_b", int'(b_ready), 0);
        issued = 0; both = 0; hold = 0; cyc_n = 0;
        while (issued < 6 && cyc_n < 600) begin
            cycle();
            cyc_n++;
            if (a_ready && b_ready) both++;
            if (draw) begin
                chk("t2_order", tri_o, (issued % 2 == 0) ? mk(100 + issued / 2) : mk(200 + issued / 2));
                issued++;
                busy = 1'b1;
                hold = 5;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) busy = 1'b0;
            end
        end
        chki("t2_issued", issued, 6);
        chki("t2_both_ready", both, 0);

        // fill the FIFO while the engine is stalled busy
        do_reset();
        busy = 1'b1; settle();
        start_a(300);
        repeat (8) cycle();
        chki("t3_accepted", a_idx, 5);
        chki("t3_level_full", int'(level), 4);
        chki("t3_a_ready_full", int'(a_ready), 0);
        b_valid = 1'b1; b_base = 900; b_idx = 0; b_tri = mk(900); settle();
        chki("t3_b_ready_full", int'(b_ready), 0);
        b_valid = 1'b0; settle();
        busy = 1'b0; settle();
        n = 0; nr = 0;
        do begin
            cycle();
            n++;
            if (!draw && a_ready) nr++;
        end while (!draw && n < 40);
        chki("t3_draw_seen", int'(draw), 1);
        chki("t3_no_early_push", nr, 0);
        chki("t3_level_after_pop", int'(level), 3);
        chki("t3_ready_after_pop", int'(a_ready), 1);
        chk("t3_tri", tri_o, mk(301));
        cycle();
        chki("t3_refill", int'(level), 4);
        chki("t3_accepted2", a_idx, 6);

        // busy timeout re-issues the same triangle every BUSY_TIMEOUT+1 cycles
        do_reset();
        start_a(400);
        cycle();
        a_valid = 1'b0; settle();
        wait_draw(10, n);
        chki("t4_first_draw", int'(draw), 1);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin cycle(); n++; end while (!draw && n < 20);
            chki("t4_period", n, 5);
            chk("t4_tri_stable", tri_o, mk(400));
        end
        busy = 1'b1; settle();
        nd = 0;
        repeat (3) begin cycle(); if (draw) nd++; end
        busy = 1'b0; settle();
        wait_done(30, n, nd2);
        chki("t4_done_lat", n, 9);
        chki("t4_extra_draws", nd + nd2, 0);
        chki("t4_count", int'(count), 1);

        // flush with 3 queued and 1 in flight
        do_reset();
        busy = 1'b1; settle();
        start_a(500);
        n = 0;
        while (a_idx < 4 && n < 20) begin cycle(); n++; end
        a_valid = 1'b0; settle();
        chki("t5_level", int'(level), 3);
        flush = 1'b1; a_valid = 1'b1; settle();
        chki("t5_flush_ready", int'(a_ready), 0);
        cycle();
        flush = 1'b0; a_valid = 1'b0; settle();
        chki("t5_level_flushed", int'(level), 0);
        chki("t5_no_push", a_idx, 4);
        busy = 1'b0; settle();
        wait_done(30, n, nd);
        chki("t5_done_lat", n, 9);
        chki("t5_count", int'(count), 1);
        nd = 0;
        repeat (20) begin cycle(); if (draw) nd++; end
        chki("t5_no_draw", nd, 0);
        chki("t5_count_hold", int'(count), 1);
        chki("t5_idle", int'(idle), 1);
        // flush wins over a simultaneous pop
        start_a(600);
        cycle();
        a_valid = 1'b0; flush = 1'b1; settle();
        chki("t5b_level", int'(level), 1);
        cycle();
        flush = 1'b0; settle();
        chki("t5b_level_flushed", int'(level), 0);
        nd = 0;
        repeat (6) begin cycle(); if (draw) nd++; end
        chki("t5b_no_draw", nd, 0);
        chki("t5b_idle", int'(idle), 1);

        // reset in DRAIN with 2 queued, then count wrap
        do_reset();
        force dut.tri_count_q = 16'hFFFF;
        cycle();
        release dut.tri_count_q;
        settle();
        chki("t6_preload", int'(count), 16'hFFFF);
        busy = 1'b1; settle();
        start_a(700);
        n = 0;
        while (a_idx < 3 && n < 20) begin cycle(); n++; end
        a_valid = 1'b0; settle();
        chki("t6_level", int'(level), 2);
        busy = 1'b0; settle();
        repeat (3) cycle();
        reset = 1'b1; settle();
        cycle();
        chki("t6_rst_draw", int'(draw), 0);
        chk("t6_rst_tri", tri_o, '0);
        chki("t6_rst_done", int'(tri_done), 0);
        chki("t6_rst_count", int'(count), 0);
        chki("t6_rst_level", int'(level), 0);
        reset = 1'b0; settle();
        nd = 0; ndone = 0;
        repeat (15) begin cycle(); if (draw) nd++; if (tri_done) ndone++; end
        chki("t6_no_draw", nd, 0);
        chki("t6_no_done", ndone, 0);
        force dut.tri_count_q = 16'hFFFF;
        cycle();
        release dut.tri_count_q;
        settle();
        start_a(800);
        cycle();
        a_valid = 1'b0; settle();
        wait_draw(10, n);
        chki("t6_draw", int'(draw), 1);
        chk("t6_tri", tri_o, mk(800));
        busy = 1'b1; settle();
        repeat (3) cycle();
        busy = 1'b0; settle();
        wait_done(30, n, nd);
        chki("t6_wrap_done", int'(tri_done), 1);
        chki("t6_wrap", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
